// File: rtl/heading_hold_controller.sv
// Heading-hold controller: turns toward a latched target yaw, settles within a
// deadband, then drives forward while holding heading; a timer guards turn/settle.
module heading_hold_controller #(
  parameter logic [2:0]  MOTOR_FORWARD  = 3'd0,
  parameter logic [2:0]  MOTOR_LEFT     = 3'd1,
  parameter logic [2:0]  MOTOR_RIGHT    = 3'd2,
  parameter logic [2:0]  MOTOR_STOP     = 3'd3,
  parameter int unsigned SETTLE_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_en,
  input  logic [15:0] yaw,
  input  logic        yaw_valid,
  input  logic [15:0] target_yaw,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  deadband,
  input  logic [31:0] turn_timeout,
  output logic [2:0]  motor_out,
  output logic [15:0] yaw_error,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SAMPLE, S_TURN, S_SETTLE, S_HOLD, S_FAULT
  } state_t;

  localparam logic [7:0] SETTLE_N = SETTLE_SAMPLES[7:0];

  state_t       state_q, state_d;
  logic [15:0]  target_q, target_d;
  logic [31:0]  timer_q, timer_d;
  logic [7:0]   count_q, count_d;
  logic         right_q, right_d;
  logic [2:0]   motor_q, motor_d;
  logic [15:0]  yaw_err_q, yaw_err_d;
  logic         done_q, done_d;

  logic signed [16:0] diff, norm;
  logic [9:0]         abs10;
  logic               in_band, drift, err_pos, active;

  // Heading error folded into a single turn of the circle (one fold suffices
  // for headings inside the nominal gyro range).
  always_comb begin
    diff = $signed({1'b0, target_q}) - $signed({1'b0, yaw});
    norm = diff;
    if (diff > 17'sd180)
      norm = diff - 17'sd360;
    else if (diff <= -17'sd180)
      norm = diff + 17'sd360;
    abs10   = norm[16] ? 10'(-norm) : norm[9:0];
    in_band = abs10 <= {2'b00, deadband};
    drift   = abs10 > {1'b0, deadband, 1'b0};
    err_pos = !norm[16] && (norm != 17'sd0);
  end

  assign active = (state_q == S_WAIT_SAMPLE) || (state_q == S_TURN) || (state_q == S_SETTLE);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    timer_d   = timer_q;
    count_d   = count_q;
    right_d   = right_q;
    yaw_err_d = yaw_err_q;

    if (ctrl_en && yaw_valid)
      yaw_err_d = norm[15:0];

    if (abort) begin
      state_d = S_IDLE;
      timer_d = '0;
      count_d = '0;
    end else if (ctrl_en) begin
      if (active && (turn_timeout != '0) && (timer_q == turn_timeout)) begin
        state_d = S_FAULT;
      end else if (start && (state_q == S_IDLE || state_q == S_HOLD || state_q == S_FAULT)) begin
        target_d = target_yaw;
        timer_d  = '0;
        count_d  = '0;
        state_d  = S_WAIT_SAMPLE;
      end else begin
        if (active && (timer_q != '1))
          timer_d = timer_q + 32'd1;
        if (yaw_valid) begin
          unique case (state_q)
            S_WAIT_SAMPLE, S_TURN: begin
              if (in_band) begin
                count_d = 8'd1;
                state_d = (SETTLE_N > 8'd1) ? S_SETTLE : S_HOLD;
              end else begin
                state_d = S_TURN;
                right_d = err_pos;
              end
            end
            S_SETTLE: begin
              if (in_band) begin
                count_d = count_q + 8'd1;
                if (count_d >= SETTLE_N)
                  state_d = S_HOLD;
              end else begin
                count_d = '0;
                state_d = S_TURN;
                right_d = err_pos;
              end
            end
            S_HOLD: begin
              if (drift) begin
                state_d = S_TURN;
                timer_d = '0;
                right_d = err_pos;
              end
            end
            default: ;
          endcase
        end
      end
    end

    // Motor command is registered from the next state so it tracks transitions
    // with no extra cycle; a disabled controller always commands stop.
    motor_d = MOTOR_STOP;
    if (ctrl_en) begin
      unique case (state_d)
        S_TURN:  motor_d = right_d ? MOTOR_RIGHT : MOTOR_LEFT;
        S_HOLD:  motor_d = MOTOR_FORWARD;
        default: motor_d = MOTOR_STOP;
      endcase
    end

    done_d = (state_d == S_HOLD) && (state_q != S_HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      target_q  <= 16'd360;
      timer_q   <= '0;
      count_q   <= '0;
      right_q   <= 1'b0;
      motor_q   <= MOTOR_STOP;
      yaw_err_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      right_q   <= right_d;
      motor_q   <= motor_d;
      yaw_err_q <= yaw_err_d;
      done_q    <= done_d;
    end
  end

  assign motor_out   = motor_q;
  assign yaw_error   = yaw_err_q;
  assign busy        = active;
  assign done        = done_q;
  assign timeout_err = (state_q == S_FAULT);

endmodule

// File: doc/heading_hold_controller.md
HEADING_HOLD_CONTROLLER -- requirements
Module: heading_hold_controller

Interface
REQ-001 SHALL have parameter MOTOR_FORWARD, default 0, motor_out code for drive straight.
REQ-002 SHALL have parameter MOTOR_LEFT, default 1, motor_out code for rotate toward decreasing yaw.
REQ-003 SHALL have parameter MOTOR_RIGHT, default 2, motor_out code for rotate toward increasing yaw.
REQ-004 SHALL have parameter MOTOR_STOP, default 3, motor_out code for all motors off.
REQ-005 SHALL have parameter SETTLE_SAMPLES, default 4, consecutive in-band samples required before HOLD.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous active-low reset (asserted when 0).
REQ-008 SHALL have port ctrl_en, input, 1 bit, controller enable.
REQ-009 SHALL have port yaw, input, 16 bits, unsigned heading from the gyro driver (nominal 90..630, 360 = start heading).
REQ-010 SHALL have port yaw_valid, input, 1 bit, one-cycle pulse marking a new yaw sample.
REQ-011 SHALL have port target_yaw, input, 16 bits, unsigned requested heading, sampled on start.
REQ-012 SHALL have port start, input, 1 bit, one-cycle pulse requesting a new heading.
REQ-013 SHALL have port abort, input, 1 bit, one-cycle pulse forcing IDLE.
REQ-014 SHALL have port deadband, input, 8 bits, unsigned tolerance in yaw units.
REQ-015 SHALL have port turn_timeout, input, 32 bits, maximum cycles in TURN/SETTLE; 0 disables the timeout.
REQ-016 SHALL have port motor_out, output, 3 bits, registered motor command to the motor driver and gyro driver.
REQ-017 SHALL have port yaw_error, output, 16 bits, signed normalized error, registered.
REQ-018 SHALL have outputs busy, done and timeout_err, each 1 bit.

Function
REQ-019 SHALL compute err = target_latched - yaw as a 17-bit signed value, then normalize: if err > 180, subtract 360; if err <= -180, add 360; result range -179..180.
REQ-020 SHALL update yaw_error on each accepted yaw_valid sample, 1-cycle latency.
REQ-021 SHALL define in-band as |err| <= deadband and drift as |err| > 2*deadband, using 10-bit comparisons.
REQ-022 SHALL implement states IDLE, WAIT_SAMPLE, TURN, SETTLE, HOLD, FAULT.
REQ-023 IDLE: motor_out=MOTOR_STOP, busy=0; start latches target_yaw, clears the timer and timeout_err, and moves to WAIT_SAMPLE.
REQ-024 WAIT_SAMPLE: busy=1; on yaw_valid, go to SETTLE (count=1) if in-band, else to TURN.
REQ-025 TURN: motor_out=MOTOR_RIGHT if err>0, else MOTOR_LEFT; re-evaluated on every yaw_valid so that a sign flip reverses direction; in-band goes to SETTLE with count=1 and motor_out=MOTOR_STOP.
REQ-026 SETTLE: motor_out=MOTOR_STOP; each in-band sample increments count; an out-of-band sample returns to TURN and clears count; count==SETTLE_SAMPLES goes to HOLD.
REQ-027 HOLD entry: done pulses high for exactly 1 cycle, busy=0, motor_out=MOTOR_FORWARD; a drift sample goes to TURN with busy=1 and the timer cleared.
REQ-028 Timer SHALL increment each enabled cycle in WAIT_SAMPLE/TURN/SETTLE; at timer==turn_timeout (nonzero) go to FAULT.
REQ-029 FAULT: motor_out=MOTOR_STOP, timeout_err=1 held, busy=0; start restarts as in IDLE.
REQ-030 start SHALL be accepted only in IDLE, HOLD and FAULT, and ignored elsewhere.
REQ-031 Priority SHALL be abort > timeout > start > yaw_valid; abort in any state goes to IDLE, clears done, busy and timeout_err, and sets motor_out=MOTOR_STOP next cycle.
REQ-032 ctrl_en=0 SHALL freeze state, timer and count, ignore start and yaw_valid, and register motor_out=MOTOR_STOP; on re-enable the frozen state's command resumes next cycle.
REQ-033 Timer SHALL saturate at 2^32-1 and not wrap.

Reset
REQ-034 While reset=0: state=IDLE, motor_out=MOTOR_STOP, yaw_error=0, busy=0, done=0, timeout_err=0, timer=0, count=0, target_latched=360.
REQ-035 Reset asserted mid-turn SHALL take effect immediately (asynchronous) and suspend motor commands.

Verification
REQ-036 deadband=5, target=360, start, yaw=400 -> yaw_error=-40, motor_out=1, busy=1.
REQ-037 From REQ-036, yaw samples 370, 362, 361, 360, 359 -> TURN until 362, then STOP for 4 in-band samples, then done pulse of 1 cycle, motor_out=0.
REQ-038 Wrap: target=620, yaw=100 -> yaw_error=+160, motor_out=2; target=100, yaw=620 -> yaw_error=-160, motor_out=1.
REQ-039 Overshoot/drift: in SETTLE, yaw gives err=+8 -> TURN right; in HOLD with deadband=5, err=11 -> TURN, err=10 -> stays HOLD.
REQ-040 turn_timeout=50, yaw held at err=40 -> FAULT at cycle 50, timeout_err=1, motor_out=3; abort -> IDLE, timeout_err=0.
REQ-041 start and abort in the same cycle -> IDLE; reset pulse during TURN -> motor_out=3 immediately.
